// File: rtl/ahb_slave_port_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ahb_slave_port_arbiter
//   Decides which master owns one shared AHB slave port. It produces the
//   one-hot address-phase select for the master-side payload mux and a
//   registered data-phase select for write-data muxing and response routing.
//   Ownership is held across fixed-length bursts, undefined-length INCR
//   bursts and locked sequences. The port is re-arbitrated only at legal
//   transfer boundaries.
//
// Parameters
//   MASTER_NUM : number of masters sharing this slave port (2..16)
//   RR_EN      : 1 = round-robin, 0 = fixed priority (master 0 highest)
//
// Ports
//   HCLK      in   system clock
//   HRESETn   in   synchronous active-low reset
//   hreq      in   per-master request (decoded HSEL targets this slave)
//   hlock     in   per-master HLOCK
//   htrans    in   per-master HTRANS, master m at [2m+1:2m]
//   hburst    in   per-master HBURST, master m at [3m+2:3m]
//   hready    in   HREADY of the slave port (transfer-complete strobe)
//   addr_sel  out  one-hot (or zero) address-phase owner
//   data_sel  out  one-hot (or zero) data-phase owner
//   hmaster   out  binary index of the addr_sel owner, 0 when no owner
//   hmastlock out  owner is performing a locked transfer
// ----------------------------------------------------------------------------
module ahb_slave_port_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter bit RR_EN      = 1'b1
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic [MASTER_NUM-1:0]         hreq,
   input  logic [MASTER_NUM-1:0]         hlock,
   input  logic [2*MASTER_NUM-1:0]       htrans,
   input  logic [3*MASTER_NUM-1:0]       hburst,
   input  logic                          hready,
   output logic [MASTER_NUM-1:0]         addr_sel,
   output logic [MASTER_NUM-1:0]         data_sel,
   output logic [$clog2(MASTER_NUM)-1:0] hmaster,
   output logic                          hmastlock
);

   localparam int IW = $clog2(MASTER_NUM);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [2:0] BURST_INCR = 3'd1;

   typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_LOCKED} state_t;

   state_t        state;
   logic [3:0]    beat_cnt;    // beats still to come after the last accepted one
   logic          undef_len;   // current burst is undefined-length INCR
   logic [IW-1:0] rr_ptr;

   // Beats-1 for each HBURST encoding; INCR (undefined length) loads 0.
   function automatic logic [3:0] burst_beats(input logic [2:0] burst);
      case (burst)
         3'd2, 3'd3: return 4'd3;    // WRAP4 / INCR4
         3'd4, 3'd5: return 4'd7;    // WRAP8 / INCR8
         3'd6, 3'd7: return 4'd15;   // WRAP16 / INCR16
         default:    return 4'd0;    // SINGLE / INCR
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Current owner's view of the bus
   // ---------------------------------------------------------------------
   logic       own_req;
   logic       own_lock;
   logic [1:0] own_trans;
   logic [2:0] own_burst;

   // NOTE: every signal driven here gets a default first, so no path through
   // the loop can leave it unassigned and infer a latch.
   always_comb begin
      own_req   = 1'b0;
      own_lock  = 1'b0;
      own_trans = TR_IDLE;
      own_burst = 3'd0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (hmaster == IW'(i)) begin
            own_req   = hreq[i];
            own_lock  = hlock[i];
            own_trans = htrans[2*i +: 2];
            own_burst = hburst[3*i +: 3];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Beat accounting and arbitration point
   // ---------------------------------------------------------------------
   logic [3:0] cnt_next;
   logic       undef_next;
   logic       xfer;
   logic       last_beat;
   logic       arb;

   always_comb begin
      cnt_next   = beat_cnt;
      undef_next = undef_len;
      if (own_trans == TR_NONSEQ) begin
         cnt_next   = burst_beats(own_burst);
         undef_next = (own_burst == BURST_INCR);
      end else if (own_trans == TR_SEQ && beat_cnt != 4'd0) begin
         cnt_next = beat_cnt - 4'd1;
      end
   end

   assign xfer      = (own_trans == TR_NONSEQ) || (own_trans == TR_SEQ);
   // The beat being accepted now is the last one of a defined-length burst.
   assign last_beat = xfer && (cnt_next == 4'd0) && !undef_next;
   // A lock held by the owner overrides every release condition.
   assign arb = hready && ((state == ST_IDLE) ||
                           (!own_lock && ((own_trans == TR_IDLE) || !own_req || last_beat)));

   // ---------------------------------------------------------------------
   // Winner search: rotating start in round-robin mode, index 0 otherwise.
   // Since the pointer moves past each grantee, a releasing owner is last.
   // ---------------------------------------------------------------------
   logic          win_found;
   logic [IW-1:0] win_idx;
   int            cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         cand = (RR_EN ? int'(rr_ptr) : 0) + i;
         if (cand >= MASTER_NUM) cand = cand - MASTER_NUM;
         if (!win_found && hreq[IW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registered state and outputs. Nothing moves while hready=0, so the
   // grant is stable across wait states.
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         addr_sel  <= '0;
         data_sel  <= '0;
         hmaster   <= '0;
         hmastlock <= 1'b0;
         beat_cnt  <= 4'd0;
         undef_len <= 1'b0;
         rr_ptr    <= '0;
      end else if (hready) begin
         data_sel <= xfer ? addr_sel : '0;
         if (state != ST_IDLE) begin
            beat_cnt  <= cnt_next;
            undef_len <= undef_next;
         end
         if (arb) begin
            if (win_found) begin
               state     <= ST_OWNED;
               addr_sel  <= MASTER_NUM'(1) << win_idx;
               hmaster   <= win_idx;
               hmastlock <= hlock[win_idx];
               if (RR_EN)
                  rr_ptr <= (win_idx == IW'(MASTER_NUM-1)) ? '0 : win_idx + IW'(1);
            end else begin
               state     <= ST_IDLE;
               addr_sel  <= '0;
               hmaster   <= '0;
               hmastlock <= 1'b0;
            end
         end else begin
            hmastlock <= own_lock;
            if (own_lock && own_trans == TR_NONSEQ)
               state <= ST_LOCKED;
            else if (!own_lock && own_trans != TR_BUSY)
               state <= ST_OWNED;
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ahb_slave_port_arbiter
//   Directed stimulus for a 4-master port. The stimulus process pushes the
//   expected post-edge outputs for each cycle into a queue; an independent
//   monitor pops one entry after every rising edge and compares. A second
//   instance with fixed priority shares the inputs and is checked only
//   where its expectation is meaningful.
// ----------------------------------------------------------------------------
module tb_ahb_slave_port_arbiter;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5,
                          WRAP16 = 3'd6, INCR16 = 3'd7;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [3:0]  hreq, hlock;
   logic [7:0]  htrans;
   logic [11:0] hburst;
   logic        hready;

   logic [3:0]  addr_sel, data_sel, fp_addr_sel, fp_data_sel;
   logic [1:0]  hmaster, fp_hmaster;
   logic        hmastlock, fp_hmastlock;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic [3:0] a;
      logic [3:0] d;
      logic       l;
      bit         fchk;
      logic [3:0] fa;
   } exp_t;

   exp_t sb_q[$];

   always #5 HCLK = ~HCLK;

   ahb_slave_port_arbiter #(.MASTER_NUM(4), .RR_EN(1'b1)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .hreq(hreq), .hlock(hlock),
      .htrans(htrans), .hburst(hburst), .hready(hready),
      .addr_sel(addr_sel), .data_sel(data_sel), .hmaster(hmaster),
      .hmastlock(hmastlock)
   );

   ahb_slave_port_arbiter #(.MASTER_NUM(4), .RR_EN(1'b0)) u_fp (
      .HCLK(HCLK), .HRESETn(HRESETn), .hreq(hreq), .hlock(hlock),
      .htrans(htrans), .hburst(hburst), .hready(hready),
      .addr_sel(fp_addr_sel), .data_sel(fp_data_sel), .hmaster(fp_hmaster),
      .hmastlock(fp_hmastlock)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      for (int i = 0; i < 4; i++)
         if (oh[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic set_m(input int m, input logic req, input logic lock,
                        input logic [1:0] tr, input logic [2:0] bu);
      hreq[m]           = req;
      hlock[m]          = lock;
      htrans[2*m +: 2]  = tr;
      hburst[3*m +: 3]  = bu;
   endtask

   // Drive hready for the coming edge and queue the outputs expected after it.
   task automatic step(input string name, input logic rdy, input logic [3:0] a,
                       input logic [3:0] d, input logic l,
                       input bit fchk = 1'b0, input logic [3:0] fa = 4'b0000);
      exp_t e;
      hready = rdy;
      e.name = name; e.a = a; e.d = d; e.l = l; e.fchk = fchk; e.fa = fa;
      sb_q.push_back(e);
      @(negedge HCLK);
   endtask

   // Monitor: compares one queued expectation after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge HCLK);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".addr_sel"},  32'(addr_sel),  32'(e.a));
            check({e.name, ".data_sel"},  32'(data_sel),  32'(e.d));
            check({e.name, ".hmaster"},   32'(hmaster),   32'(onehot_idx(e.a)));
            check({e.name, ".hmastlock"}, 32'(hmastlock), 32'(e.l));
            if (e.fchk)
               check({e.name, ".fp_addr_sel"}, 32'(fp_addr_sel), 32'(e.fa));
         end
      end
   end

   initial begin
      HRESETn = 1'b0;
      hready  = 1'b1;
      hreq    = '0;
      hlock   = '0;
      htrans  = '0;
      hburst  = '0;
      @(negedge HCLK);

      // Reset state
      step("reset0", 1'b1, 4'b0000, 4'b0000, 1'b0);
      step("reset1", 1'b1, 4'b0000, 4'b0000, 1'b0);
      HRESETn = 1'b1;

      // Single requester, SINGLE transfers, then release
      set_m(1, 1'b1, 1'b0, NS, SINGLE);
      step("t1_grant",   1'b1, 4'b0010, 4'b0000, 1'b0);
      step("t1_data",    1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b0, 1'b0, IDLE, SINGLE);
      step("t1_release", 1'b1, 4'b0000, 4'b0000, 1'b0);
      step("t1_idle",    1'b1, 4'b0000, 4'b0000, 1'b0);

      // Masters 0 and 2 with SINGLE transfers: RR alternates, FP holds 0
      set_m(0, 1'b1, 1'b0, NS, SINGLE);
      set_m(2, 1'b1, 1'b0, NS, SINGLE);
      for (int i = 1; i <= 6; i++)
         step("t2_rr", 1'b1, (i % 2 == 1) ? 4'b0100 : 4'b0001,
              (i == 1) ? 4'b0000 : ((i % 2 == 1) ? 4'b0001 : 4'b0100),
              1'b0, 1'b1, 4'b0001);
      set_m(0, 1'b0, 1'b0, IDLE, SINGLE);
      set_m(2, 1'b0, 1'b0, IDLE, SINGLE);
      step("t2_release", 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Master 1 INCR8 with 2 BUSY beats and 3 wait states; master 3 waiting
      set_m(1, 1'b1, 1'b0, NS, INCR8);
      set_m(3, 1'b1, 1'b0, NS, SINGLE);
      step("t3_grant", 1'b1, 4'b0010, 4'b0000, 1'b0);
      step("t3_b1",    1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b1, 1'b0, SQ, INCR8);
      step("t3_wait1", 1'b0, 4'b0010, 4'b0010, 1'b0);
      step("t3_b2",    1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b1, 1'b0, BUSY, INCR8);
      step("t3_busy1", 1'b1, 4'b0010, 4'b0000, 1'b0);
      set_m(1, 1'b1, 1'b0, SQ, INCR8);
      step("t3_b3",    1'b1, 4'b0010, 4'b0010, 1'b0);
      step("t3_wait2", 1'b0, 4'b0010, 4'b0010, 1'b0);
      step("t3_b4",    1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b1, 1'b0, BUSY, INCR8);
      step("t3_busy2", 1'b1, 4'b0010, 4'b0000, 1'b0);
      set_m(1, 1'b1, 1'b0, SQ, INCR8);
      step("t3_b5",    1'b1, 4'b0010, 4'b0010, 1'b0);
      step("t3_b6",    1'b1, 4'b0010, 4'b0010, 1'b0);
      step("t3_wait3", 1'b0, 4'b0010, 4'b0010, 1'b0);
      step("t3_b7",    1'b1, 4'b0010, 4'b0010, 1'b0);
      step("t3_b8",    1'b1, 4'b1000, 4'b0010, 1'b0);
      set_m(1, 1'b0, 1'b0, IDLE, INCR8);
      step("t3_m3",    1'b1, 4'b1000, 4'b1000, 1'b0);
      set_m(3, 1'b0, 1'b0, IDLE, SINGLE);
      step("t3_release", 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Master 0 locked INCR4 then locked SINGLE; master 1 waiting
      set_m(0, 1'b1, 1'b1, NS, INCR4);
      set_m(1, 1'b1, 1'b0, NS, SINGLE);
      step("t4_grant", 1'b1, 4'b0001, 4'b0000, 1'b1);
      step("t4_b1",    1'b1, 4'b0001, 4'b0001, 1'b1);
      set_m(0, 1'b1, 1'b1, SQ, INCR4);
      step("t4_b2",    1'b1, 4'b0001, 4'b0001, 1'b1);
      step("t4_b3",    1'b1, 4'b0001, 4'b0001, 1'b1);
      step("t4_b4",    1'b1, 4'b0001, 4'b0001, 1'b1);
      set_m(0, 1'b1, 1'b1, NS, SINGLE);
      step("t4_lock_single", 1'b1, 4'b0001, 4'b0001, 1'b1);
      set_m(0, 1'b1, 1'b0, NS, SINGLE);
      step("t4_unlock", 1'b1, 4'b0010, 4'b0001, 1'b0);
      set_m(0, 1'b0, 1'b0, IDLE, SINGLE);
      step("t4_m1",     1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b0, 1'b0, IDLE, SINGLE);
      step("t4_release", 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Master 2 WRAP16 aborted after beat 5; master 0 INCR4 reloads counter
      set_m(2, 1'b1, 1'b0, NS, WRAP16);
      set_m(0, 1'b1, 1'b0, NS, INCR4);
      step("t5_grant", 1'b1, 4'b0100, 4'b0000, 1'b0);
      step("t5_b1",    1'b1, 4'b0100, 4'b0100, 1'b0);
      set_m(2, 1'b1, 1'b0, SQ, WRAP16);
      for (int i = 2; i <= 5; i++)
         step("t5_seq", 1'b1, 4'b0100, 4'b0100, 1'b0);
      set_m(2, 1'b0, 1'b0, IDLE, WRAP16);
      step("t5_abort", 1'b1, 4'b0001, 4'b0000, 1'b0);
      set_m(3, 1'b1, 1'b0, NS, SINGLE);
      step("t5_m0_b1", 1'b1, 4'b0001, 4'b0001, 1'b0);
      set_m(0, 1'b1, 1'b0, SQ, INCR4);
      step("t5_m0_b2", 1'b1, 4'b0001, 4'b0001, 1'b0);
      step("t5_m0_b3", 1'b1, 4'b0001, 4'b0001, 1'b0);
      step("t5_m0_b4", 1'b1, 4'b1000, 4'b0001, 1'b0);
      set_m(0, 1'b0, 1'b0, IDLE, INCR4);
      set_m(3, 1'b0, 1'b0, IDLE, SINGLE);
      step("t5_defer",   1'b0, 4'b1000, 4'b0001, 1'b0);
      step("t5_release", 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Reset during an INCR16 wait state; pointer restarts at 0
      set_m(1, 1'b1, 1'b0, NS, INCR16);
      step("t6_grant", 1'b1, 4'b0010, 4'b0000, 1'b0);
      step("t6_b1",    1'b1, 4'b0010, 4'b0010, 1'b0);
      set_m(1, 1'b1, 1'b0, SQ, INCR16);
      step("t6_b2",    1'b1, 4'b0010, 4'b0010, 1'b0);
      HRESETn = 1'b0;
      step("t6_reset", 1'b0, 4'b0000, 4'b0000, 1'b0);
      HRESETn = 1'b1;
      set_m(1, 1'b0, 1'b0, IDLE, INCR16);
      set_m(0, 1'b1, 1'b0, NS, SINGLE);
      set_m(2, 1'b1, 1'b0, NS, SINGLE);
      step("t6_restart", 1'b1, 4'b0001, 4'b0000, 1'b0);
      step("t6_next",    1'b1, 4'b0100, 4'b0001, 1'b0);
      set_m(0, 1'b0, 1'b0, IDLE, SINGLE);
      set_m(2, 1'b0, 1'b0, IDLE, SINGLE);
      step("t6_release", 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 10 && sb_q.size() > 0; i++)
         @(negedge HCLK);
      n_checks++;
      if (sb_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
